// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//   Arbitrates the single VRAM write port between the character writer
//   (single-byte beats) and an internal row-clear engine. The row-clear engine
//   fills one row with FILL. Every VRAM write output is registered, and only
//   one beat is presented to VRAM at a time.
module vram_write_scheduler #(
   parameter int         COLS = 80,
   parameter int         ROWS = 30,
   parameter logic [7:0] FILL = 8'h20
) (
   input  logic       clk,
   input  logic       reset,
   // character writer side
   output logic       in_ready,
   input  logic       in_valid,
   input  logic [4:0] in_row,
   input  logic [6:0] in_col,
   input  logic [7:0] in_byte,
   // row-clear command side
   output logic       clear_ready,
   input  logic       clear_valid,
   input  logic [4:0] clear_row,
   output logic       clear_done,
   output logic       busy,
   // VRAM write port
   input  logic       write_ready,
   output logic       write_valid,
   output logic [4:0] write_row,
   output logic [6:0] write_col,
   output logic [7:0] write_byte
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PASS  = 2'd1,
      CLEAR = 2'd2
   } state_t;

   localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
   localparam logic [5:0] ROW_LIMIT = 6'(ROWS);

   state_t state;
   logic   accept;
   logic   row_in_range;

   // A beat leaves the port only when VRAM takes it.
   assign accept       = write_valid & write_ready;
   // Rows at or past ROWS are acknowledged but produce no writes.
   assign row_in_range = ({1'b0, clear_row} < ROW_LIMIT);

   // Request acceptance: only from IDLE, and clear has priority over the writer.
   assign clear_ready = (state == IDLE);
   assign in_ready    = (state == IDLE) & ~clear_valid;
   assign busy        = (state != IDLE);

   // Arbitration FSM and registered VRAM write outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         write_valid <= 1'b0;
         write_row   <= 5'd0;
         write_col   <= 7'd0;
         write_byte  <= 8'd0;
         clear_done  <= 1'b0;
      end else begin
         // NOTE: all state here uses <= so every register samples pre-edge
         // values; the default below makes clear_done a one-cycle pulse.
         clear_done <= 1'b0;
         case (state)
            IDLE: begin
               if (clear_valid) begin
                  if (row_in_range) begin
                     write_row   <= clear_row;
                     write_col   <= 7'd0;
                     write_byte  <= FILL;
                     write_valid <= 1'b1;
                     state       <= CLEAR;
                  end else begin
                     clear_done <= 1'b1;
                  end
               end else if (in_valid) begin
                  write_row   <= in_row;
                  write_col   <= in_col;
                  write_byte  <= in_byte;
                  write_valid <= 1'b1;
                  state       <= PASS;
               end
            end
            PASS: begin
               if (accept) begin
                  write_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            CLEAR: begin
               if (accept) begin
                  if (write_col == LAST_COL) begin
                     write_valid <= 1'b0;
                     clear_done  <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     write_col <= write_col + 7'd1;
                  end
               end
            end
            default: begin
               write_valid <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// tb_vram_write_scheduler
//   Transaction-level reference: every accepted command turns into a queue of
//   expected VRAM beats. The head of that queue is what the port must present.
//   DUT outputs are compared against it on every falling edge. Directed tests
//   pin the model with literal expectations; a random phase follows them.
module tb_vram_write_scheduler;

   localparam int         COLS = 80;
   localparam int         ROWS = 30;
   localparam logic [7:0] FILL = 8'h20;

   typedef struct packed {
      logic [4:0] row;
      logic [6:0] col;
      logic [7:0] data;
   } beat_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_ready, in_valid;
   logic [4:0] in_row;
   logic [6:0] in_col;
   logic [7:0] in_byte;
   logic       clear_ready, clear_valid;
   logic [4:0] clear_row;
   logic       clear_done, busy;
   logic       write_ready, write_valid;
   logic [4:0] write_row;
   logic [6:0] write_col;
   logic [7:0] write_byte;

   vram_write_scheduler #(.COLS(COLS), .ROWS(ROWS), .FILL(FILL)) dut (
      .clk(clk), .reset(reset),
      .in_ready(in_ready), .in_valid(in_valid), .in_row(in_row), .in_col(in_col), .in_byte(in_byte),
      .clear_ready(clear_ready), .clear_valid(clear_valid), .clear_row(clear_row),
      .clear_done(clear_done), .busy(busy),
      .write_ready(write_ready), .write_valid(write_valid),
      .write_row(write_row), .write_col(write_col), .write_byte(write_byte)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   beat_t exp_q[$];
   bit    m_done = 1'b0;
   bit    m_is_clear = 1'b0;
   bit    last_in_acc, last_clr_acc;
   bit    rand_ready = 1'b0;

   // observations of the DUT for directed literal checks
   beat_t obs_q[$];
   int    busy_cycles;
   int    done_cnt;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // One clock cycle: compare at the falling edge, advance the model, then move past the rising edge.
   task automatic step();
      bit    idle;
      bit    nd;
      beat_t b;
      write_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      idle = (exp_q.size() == 0);
      check("write_valid", {31'd0, write_valid}, {31'd0, !idle});
      if (!idle) check("write_beat", {12'd0, write_row, write_col, write_byte}, {12'd0, exp_q[0]});
      check("clear_done", {31'd0, clear_done}, {31'd0, m_done});
      check("busy", {31'd0, busy}, {31'd0, !idle});
      check("in_ready", {31'd0, in_ready}, {31'd0, idle & ~clear_valid});
      check("clear_ready", {31'd0, clear_ready}, {31'd0, idle});
      if (write_valid && write_ready) begin
         b.row = write_row; b.col = write_col; b.data = write_byte;
         obs_q.push_back(b);
      end
      if (busy) busy_cycles++;
      if (clear_done) done_cnt++;
      nd = 1'b0;
      last_in_acc = 1'b0;
      last_clr_acc = 1'b0;
      if (!idle) begin
         if (write_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0 && m_is_clear) nd = 1'b1;
         end
      end else if (clear_valid) begin
         last_clr_acc = 1'b1;
         if (int'(clear_row) < ROWS) begin
            m_is_clear = 1'b1;
            for (int c = 0; c < COLS; c++) begin
               b.row = clear_row; b.col = 7'(c); b.data = FILL;
               exp_q.push_back(b);
            end
         end else begin
            nd = 1'b1;
         end
      end else if (in_valid) begin
         last_in_acc = 1'b1;
         m_is_clear = 1'b0;
         b.row = in_row; b.col = in_col; b.data = in_byte;
         exp_q.push_back(b);
      end
      m_done = nd;
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [4:0] r, input logic [6:0] c, input logic [7:0] d);
      int n = 0;
      in_valid = 1'b1; in_row = r; in_col = c; in_byte = d;
      do begin step(); n++; end while (!last_in_acc && n < 4000);
      check("beat_accept_timeout", {31'd0, last_in_acc}, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic send_clear(input logic [4:0] r);
      int n = 0;
      clear_valid = 1'b1; clear_row = r;
      do begin step(); n++; end while (!last_clr_acc && n < 4000);
      check("clear_accept_timeout", {31'd0, last_clr_acc}, 32'd1);
      clear_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || m_done) && n < 4000) begin step(); n++; end
      check("idle_timeout", {31'd0, (exp_q.size() == 0 && !m_done)}, 32'd1);
   endtask

   task automatic start_test();
      obs_q.delete();
      busy_cycles = 0;
      done_cnt = 0;
   endtask

   initial begin
      beat_t e;
      reset = 1'b1;
      in_valid = 1'b0; in_row = '0; in_col = '0; in_byte = '0;
      clear_valid = 1'b0; clear_row = '0; write_ready = 1'b1;
      #1;
      check("rst_write_valid", {31'd0, write_valid}, 32'd0);
      check("rst_write_bus", {12'd0, write_row, write_col, write_byte}, 32'd0);
      check("rst_clear_done", {31'd0, clear_done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;

      // 1: single writer beat
      start_test();
      send_beat(5'd3, 7'd10, 8'h41);
      wait_idle();
      check("t1_count", obs_q.size(), 32'd1);
      if (obs_q.size() > 0) check("t1_beat", {12'd0, obs_q[0]}, {12'd0, 5'd3, 7'd10, 8'h41});
      check("t1_busy_cycles", busy_cycles, 32'd1);

      // 2: clear row 5 with VRAM always ready
      start_test();
      send_clear(5'd5);
      wait_idle();
      check("t2_count", obs_q.size(), 32'd80);
      for (int i = 0; i < obs_q.size(); i++)
         check("t2_beat", {12'd0, obs_q[i]}, {12'd0, 5'd5, 7'(i), 8'h20});
      check("t2_busy_cycles", busy_cycles, 32'd80);
      check("t2_done_pulses", done_cnt, 32'd1);

      // 3: clear and writer in the same cycle
      start_test();
      clear_valid = 1'b1; clear_row = 5'd2;
      in_valid = 1'b1; in_row = 5'd0; in_col = 7'd0; in_byte = 8'h42;
      #1;
      check("t3_clear_ready", {31'd0, clear_ready}, 32'd1);
      check("t3_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      clear_valid = 1'b0;
      send_beat(5'd0, 7'd0, 8'h42);
      wait_idle();
      check("t3_count", obs_q.size(), 32'd81);
      if (obs_q.size() == 81) begin
         check("t3_last_fill", {12'd0, obs_q[79]}, {12'd0, 5'd2, 7'd79, 8'h20});
         check("t3_writer_beat", {12'd0, obs_q[80]}, {12'd0, 5'd0, 7'd0, 8'h42});
      end

      // 4: clear row 29 with random back-pressure
      start_test();
      rand_ready = 1'b1;
      send_clear(5'd29);
      wait_idle();
      rand_ready = 1'b0;
      check("t4_count", obs_q.size(), 32'd80);
      for (int i = 0; i < obs_q.size(); i++)
         check("t4_beat", {12'd0, obs_q[i]}, {12'd0, 5'd29, 7'(i), 8'h20});
      check("t4_done_pulses", done_cnt, 32'd1);

      // 5: out-of-range row
      start_test();
      send_clear(5'd31);
      check("t5_done_next_cycle", {31'd0, clear_done}, 32'd1);
      check("t5_no_valid", {31'd0, write_valid}, 32'd0);
      wait_idle();
      step();
      check("t5_count", obs_q.size(), 32'd0);
      check("t5_done_pulses", done_cnt, 32'd1);

      // 6: asynchronous reset mid-clear
      start_test();
      send_clear(5'd7);
      begin
         int n = 0;
         while (exp_q.size() != 0 && exp_q[0].col != 7'd40 && n < 200) begin step(); n++; end
      end
      check("t6_reached_col40", {25'd0, write_col}, 32'd40);
      reset = 1'b1;
      #1;
      exp_q.delete();
      m_done = 1'b0;
      check("t6_valid_async", {31'd0, write_valid}, 32'd0);
      check("t6_busy_async", {31'd0, busy}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("t6_no_done", {31'd0, clear_done}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      start_test();
      send_beat(5'd12, 7'd79, 8'h5A);
      wait_idle();
      check("t6_count", obs_q.size(), 32'd1);
      if (obs_q.size() > 0) check("t6_beat", {12'd0, obs_q[0]}, {12'd0, 5'd12, 7'd79, 8'h5A});
      check("t6_no_done_after", done_cnt, 32'd0);

      // random mix of beats, clears (including out-of-range rows) and back-pressure
      for (int k = 0; k < 40; k++) begin
         rand_ready = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 3))
            0: begin
               clear_valid = 1'b1; clear_row = 5'($urandom_range(0, 31));
               in_valid = 1'b1; in_row = 5'($urandom); in_col = 7'($urandom); in_byte = 8'($urandom);
               step();
               clear_valid = 1'b0;
               send_beat(in_row, in_col, in_byte);
            end
            1: send_clear(5'($urandom_range(0, 31)));
            default: send_beat(5'($urandom), 7'($urandom), 8'($urandom));
         endcase
         repeat ($urandom_range(0, 2)) step();
      end
      wait_idle();
      rand_ready = 1'b0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
